// File: rtl/pcie_tx_pkg.sv
// Shared types and constants for the PCIe TX credit arbiter and its credit counters.
package pcie_tx_pkg;
    localparam int HDR_CDT_WIDTH  = 8;
    localparam int DATA_CDT_WIDTH = 12;

    typedef enum logic [1:0] {
        CDT_P   = 2'd0,
        CDT_NP  = 2'd1,
        CDT_CPL = 2'd2
    } cdt_type_e;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_XFER = 2'd2
    } arb_state_e;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction
endpackage

// File: rtl/pcie_credit_counter.sv
// One flow-control credit counter: load with infinite flag, consume, return,
// saturating at all-ones, plus a sufficient(need) compare.
module pcie_credit_counter
    import pcie_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             force_inf,
    input  logic             consume,
    input  logic [WIDTH-1:0] need,
    input  logic             ret,
    input  logic [WIDTH-1:0] ret_val,
    output logic             sufficient
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             inf_q, inf_d;
    logic [WIDTH:0]   sum;

    always_comb begin
        cnt_d = cnt_q;
        inf_d = inf_q;
        // Consume never exceeds the count (grant requires sufficiency), so one
        // extra bit holds cur - need + ret without wrapping.
        sum = {1'b0, cnt_q} - (consume ? {1'b0, need} : '0) + (ret ? {1'b0, ret_val} : '0);
        if (load) begin
            cnt_d = force_inf ? '0 : load_val;
            inf_d = force_inf || (load_val == '0);
        end else if (!inf_q) begin
            cnt_d = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            inf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            inf_q <= inf_d;
        end
    end

    assign sufficient = inf_q || (cnt_q >= need);
endmodule

// File: rtl/pcie_tx_credit_arbiter.sv
// Round-robin whole-TLP arbiter for P/NP/CPL onto tx_st_*, gated by local credit counters.
// PCIE_TX_ARB_INF_CPL_EN: CPL credits hard-wired infinite. States: INIT load | IDLE arbitrate | XFER stream TLP.
module pcie_tx_credit_arbiter #(
    parameter int SEG_COUNT      = 2,
    parameter int SEG_DATA_WIDTH = 256,
    parameter int NUM_SRC        = 3,
    parameter int HDR_CDT_WIDTH  = pcie_tx_pkg::HDR_CDT_WIDTH,
    parameter int DATA_CDT_WIDTH = pcie_tx_pkg::DATA_CDT_WIDTH
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_SRC*SEG_COUNT*SEG_DATA_WIDTH-1:0] s_data,
    input  logic [NUM_SRC*SEG_COUNT-1:0]                s_sop,
    input  logic [NUM_SRC*SEG_COUNT-1:0]                s_eop,
    input  logic [NUM_SRC*SEG_COUNT-1:0]                s_valid,
    output logic [NUM_SRC-1:0]                          s_ready,
    input  logic [NUM_SRC*DATA_CDT_WIDTH-1:0]           s_data_cdts,
    output logic [SEG_COUNT*SEG_DATA_WIDTH-1:0]         tx_st_data,
    output logic [SEG_COUNT-1:0]                        tx_st_sop,
    output logic [SEG_COUNT-1:0]                        tx_st_eop,
    output logic [SEG_COUNT-1:0]                        tx_st_valid,
    input  logic                                        tx_st_ready,
    input  logic [HDR_CDT_WIDTH-1:0]                    tx_ph_cdts,
    input  logic [HDR_CDT_WIDTH-1:0]                    tx_nph_cdts,
    input  logic [HDR_CDT_WIDTH-1:0]                    tx_cplh_cdts,
    input  logic [DATA_CDT_WIDTH-1:0]                   tx_pd_cdts,
    input  logic [DATA_CDT_WIDTH-1:0]                   tx_npd_cdts,
    input  logic [DATA_CDT_WIDTH-1:0]                   tx_cpld_cdts,
    input  logic                                        cdt_ret_valid,
    input  logic [1:0]                                  cdt_ret_type,
    input  logic [HDR_CDT_WIDTH-1:0]                    cdt_ret_hdr,
    input  logic [DATA_CDT_WIDTH-1:0]                   cdt_ret_data,
    output logic [NUM_SRC-1:0]                          arb_grant,
    output logic                                        init_done
);
    import pcie_tx_pkg::*;

    localparam int BEAT_W = SEG_COUNT * SEG_DATA_WIDTH;

`ifdef PCIE_TX_ARB_INF_CPL_EN
    localparam logic [NUM_SRC-1:0] FORCE_INF = NUM_SRC'(3'b100);
`else
    localparam logic [NUM_SRC-1:0] FORCE_INF = '0;
`endif

    arb_state_e           state_q, state_d;
    logic [NUM_SRC-1:0]   grant_q, grant_d;
    logic [1:0]           ptr_q, ptr_d;
    logic                 init_done_q, init_done_d;

    logic [NUM_SRC-1:0]        hdr_ok, data_ok, eligible, consume, ret_en, win_oh;
    logic [HDR_CDT_WIDTH-1:0]  hdr_init  [NUM_SRC];
    logic [DATA_CDT_WIDTH-1:0] data_init [NUM_SRC];
    logic [DATA_CDT_WIDTH-1:0] data_need [NUM_SRC];
    logic                      load, found, eop_hs;
    logic [1:0]                win_idx, gidx;

    assign hdr_init[0]  = tx_ph_cdts;
    assign hdr_init[1]  = tx_nph_cdts;
    assign hdr_init[2]  = tx_cplh_cdts;
    assign data_init[0] = tx_pd_cdts;
    assign data_init[1] = tx_npd_cdts;
    assign data_init[2] = tx_cpld_cdts;

    // Source index doubles as credit type: 0=P, 1=NP, 2=CPL.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_cdt
        assign data_need[i] = s_data_cdts[i*DATA_CDT_WIDTH +: DATA_CDT_WIDTH];
        assign ret_en[i]    = cdt_ret_valid && (cdt_ret_type == cdt_type_e'(i)) && !FORCE_INF[i];
        assign eligible[i]  = s_valid[i*SEG_COUNT] && s_sop[i*SEG_COUNT] && hdr_ok[i] && data_ok[i];

        pcie_credit_counter #(.WIDTH(HDR_CDT_WIDTH)) u_hdr (
            .clk        (clk),
            .rst        (rst),
            .load       (load),
            .load_val   (hdr_init[i]),
            .force_inf  (FORCE_INF[i]),
            .consume    (consume[i]),
            .need       (HDR_CDT_WIDTH'(1)),
            .ret        (ret_en[i]),
            .ret_val    (cdt_ret_hdr),
            .sufficient (hdr_ok[i])
        );

        pcie_credit_counter #(.WIDTH(DATA_CDT_WIDTH)) u_data (
            .clk        (clk),
            .rst        (rst),
            .load       (load),
            .load_val   (data_init[i]),
            .force_inf  (FORCE_INF[i]),
            .consume    (consume[i]),
            .need       (data_need[i]),
            .ret        (ret_en[i]),
            .ret_val    (cdt_ret_data),
            .sufficient (data_ok[i])
        );
    end

    always_comb begin
        int idx;
        found   = 1'b0;
        win_idx = ptr_q;
        win_oh  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(ptr_q) + k) % NUM_SRC;
            if (!found && eligible[idx]) begin
                found       = 1'b1;
                win_idx     = idx[1:0];
                win_oh[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q[i]) gidx = 2'(i);
        end
    end

    // Zero-latency mirror of the granted source; nothing is buffered.
    always_comb begin
        tx_st_data  = '0;
        tx_st_sop   = '0;
        tx_st_eop   = '0;
        tx_st_valid = '0;
        s_ready     = '0;
        if (state_q == ST_XFER) begin
            tx_st_data  = s_data[gidx*BEAT_W +: BEAT_W];
            tx_st_sop   = s_sop[gidx*SEG_COUNT +: SEG_COUNT];
            tx_st_eop   = s_eop[gidx*SEG_COUNT +: SEG_COUNT];
            tx_st_valid = s_valid[gidx*SEG_COUNT +: SEG_COUNT];
            s_ready     = grant_q & {NUM_SRC{tx_st_ready}};
        end
    end

    assign eop_hs = tx_st_ready && (|(tx_st_valid & tx_st_eop));

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        init_done_d = init_done_q;
        load        = 1'b0;
        consume     = '0;
        case (state_q)
            ST_INIT: begin
                load        = 1'b1;
                init_done_d = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_IDLE: begin
                if (found) begin
                    grant_d = win_oh;
                    consume = win_oh;
                    ptr_d   = rr_next(win_idx);
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (eop_hs) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            grant_q     <= '0;
            ptr_q       <= 2'd0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            init_done_q <= init_done_d;
        end
    end

    assign arb_grant = grant_q;
    assign init_done = init_done_q;
endmodule
